// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider arbiter.
//  - state_e       : sequencer states
//  - DIV_WIDTH     : default operand/result width of the shared divider
//  - DIV0_QUOTIENT : quotient returned for a zero divisor (all ones)
package div_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DIV_WIDTH = 13;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//  req_i    : request vector
//  ptr_i    : index of the last granted client (lowest priority)
//  onehot_o : one-hot of the first set request after ptr_i, wrapping
//  idx_o    : binary index of that request
//  valid_o  : any request set
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    // Scan ptr+1 .. ptr+N_REQ so the last owner is visited last.
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one sequential divider among N_REQ clients.
//  clk_i, reset_i                : clock, asynchronous active-high reset
//  req_i, req_sign_i             : level requests and per-client signed flag
//  req_dividend_i, req_divisor_i : packed operands, client i at [i*WIDTH +: WIDTH]
//  grant_o                       : one-hot pulse, operands captured at this edge
//  resp_valid_o                  : one-hot pulse to the owning client
//  resp_quotient_o/remainder_o   : result, held until the next response
//  resp_err_o                    : divide-by-zero or divider timeout
//  busy_o                        : sequencer not idle
//  div_start_o, div_sign_o, div_dividend_o, div_divider_o : divider request side
//  div_quotient_i, div_remainder_i, div_ready_i            : divider result side
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = DIV_WIDTH,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       req_sign_i,
  input  logic [N_REQ*WIDTH-1:0] req_dividend_i,
  input  logic [N_REQ*WIDTH-1:0] req_divisor_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       resp_valid_o,
  output logic [WIDTH-1:0]       resp_quotient_o,
  output logic [WIDTH-1:0]       resp_remainder_o,
  output logic                   resp_err_o,
  output logic                   busy_o,
  output logic                   div_start_o,
  output logic                   div_sign_o,
  output logic [WIDTH-1:0]       div_dividend_o,
  output logic [WIDTH-1:0]       div_divider_o,
  input  logic [WIDTH-1:0]       div_quotient_i,
  input  logic [WIDTH-1:0]       div_remainder_i,
  input  logic                   div_ready_i
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // All-ones at whatever width this instance uses.
  localparam logic [WIDTH-1:0] Div0Q = {WIDTH{DIV0_QUOTIENT[0]}};

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q, owner_q;
  logic [TmrW-1:0]   timer_q;
  logic              sign_q, err_q, start_q, busy_q;
  logic [WIDTH-1:0]  dividend_q, divisor_q, quot_q, rem_q;
  logic [N_REQ-1:0]  resp_valid_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid, can_grant;
  logic [WIDTH-1:0]  pick_dividend, pick_divisor;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign pick_dividend = req_dividend_i[32'(pick_idx)*WIDTH +: WIDTH];
  assign pick_divisor  = req_divisor_i[32'(pick_idx)*WIDTH +: WIDTH];

  // A divider still finishing an older op (e.g. across a reset) holds ready low.
  assign can_grant = (state_q == StIdle) && div_ready_i && pick_valid && !reset_i;
  assign grant_o   = can_grant ? pick_onehot : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      ptr_q        <= IdxW'(N_REQ - 1);
      owner_q      <= '0;
      timer_q      <= '0;
      sign_q       <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      start_q      <= 1'b0;
      resp_valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (can_grant) begin
            ptr_q      <= pick_idx;
            owner_q    <= pick_idx;
            sign_q     <= req_sign_i[pick_idx];
            dividend_q <= pick_dividend;
            divisor_q  <= pick_divisor;
            busy_q     <= 1'b1;
            if (pick_divisor == '0) begin
              // Answered locally; the divider is never started.
              quot_q       <= Div0Q;
              rem_q        <= pick_dividend;
              err_q        <= 1'b1;
              resp_valid_q <= pick_onehot;
              state_q      <= StResp;
            end else begin
              start_q <= 1'b1;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          // Divider drops ready one cycle after start; ignore the stale high.
          state_q <= StWait;
        end
        StWait: begin
          if (div_ready_i) begin
            quot_q       <= div_quotient_i;
            rem_q        <= div_remainder_i;
            err_q        <= 1'b0;
            resp_valid_q <= N_REQ'(1) << owner_q;
            state_q      <= StResp;
          end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
            quot_q       <= '0;
            rem_q        <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= N_REQ'(1) << owner_q;
            state_q      <= StResp;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid_o     = resp_valid_q;
  assign resp_quotient_o  = quot_q;
  assign resp_remainder_o = rem_q;
  assign resp_err_o       = err_q;
  assign busy_o           = busy_q;
  assign div_start_o      = start_q;
  assign div_sign_o       = sign_q;
  assign div_dividend_o   = dividend_q;
  assign div_divider_o    = divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural sequential divider.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int W  = 13;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]   req, req_sign, grant, resp_valid;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0]   resp_quotient, resp_remainder, div_dividend, div_divider;
  logic [W-1:0]   div_quotient, div_remainder;
  logic           resp_err, busy, div_start, div_sign, div_ready;

  always #5 clk = ~clk;

  div_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req_i            (req),
    .req_sign_i       (req_sign),
    .req_dividend_i   (req_dividend),
    .req_divisor_i    (req_divisor),
    .grant_o          (grant),
    .resp_valid_o     (resp_valid),
    .resp_quotient_o  (resp_quotient),
    .resp_remainder_o (resp_remainder),
    .resp_err_o       (resp_err),
    .busy_o           (busy),
    .div_start_o      (div_start),
    .div_sign_o       (div_sign),
    .div_dividend_o   (div_dividend),
    .div_divider_o    (div_divider),
    .div_quotient_i   (div_quotient),
    .div_remainder_i  (div_remainder),
    .div_ready_i      (div_ready)
  );

  int checks, errors, last_owner;
  logic [W-1:0] dvd[N], dvs[N];
  bit           sg[N];

  // ---------------- behavioural divider: ready drops late, stays low 14 cycles
  bit hang, late;
  int lowcnt;
  logic [W-1:0] mq, mr;

  initial begin
    div_ready = 1'b1; div_quotient = '0; div_remainder = '0;
    hang = 1'b0; late = 1'b0; lowcnt = 0; mq = '0; mr = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        int sa, sb;
        sa = div_sign ? int'($signed(div_dividend)) : int'({19'b0, div_dividend});
        sb = div_sign ? int'($signed(div_divider)) : int'({19'b0, div_divider});
        mq = (sb == 0) ? '0 : W'(sa / sb);
        mr = (sb == 0) ? '0 : W'(sa % sb);
        late = 1'b1;
      end else if (late) begin
        late = 1'b0; div_ready = 1'b0; lowcnt = 13;
      end else if (lowcnt > 0) begin
        lowcnt--;
      end else if (!div_ready && !hang) begin
        div_ready = 1'b1; div_quotient = mq; div_remainder = mr;
      end
    end
  end

  // ---------------- reference rules
  function automatic void ref_div(input bit s, input logic [W-1:0] a, b,
                                  output logic [W-1:0] q, r, output bit e);
    if (b == '0) begin
      q = '1; r = a; e = 1'b1;
    end else if (s) begin
      q = W'($signed(a) / $signed(b)); r = W'($signed(a) % $signed(b)); e = 1'b0;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
  endfunction

  function automatic int next_owner(input int last, input logic [N-1:0] m);
    for (int off = 1; off <= N; off++)
      if (m[(last + off) % N]) return (last + off) % N;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = dvd[i];
      req_divisor[i*W +: W]  = dvs[i];
      req_sign[i]            = sg[i];
    end
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output bit ok);
    ok = 1'b0; g = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (grant != '0) begin g = grant; ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // One transaction for client c: grant, optional req drop, response checks.
  task automatic run_one(input int c, input logic [W-1:0] eq, er, input bit ee, input bit tmo,
                         input logic [N-1:0] drop, input string tag);
    logic [N-1:0] g, oh, rv;
    logic [W-1:0] sd, sv;
    bit ok, busy_ok, quiet, ss;
    int cyc, starts, start_cyc;
    oh = N'(1) << c;
    wait_grant(g, ok);
    check({tag, " grant seen"}, 32'(ok), 1);
    if (!ok) return;
    check({tag, " grant"}, 32'(g), 32'(oh));
    check({tag, " idle busy"}, 32'(busy), 0);
    last_owner = c;
    cyc = 0; starts = 0; start_cyc = 0; busy_ok = 1'b1; quiet = 1'b1; rv = '0;
    sd = '0; sv = '0; ss = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req = req & ~drop;
      if (!busy) busy_ok = 1'b0;
      if (grant != '0) quiet = 1'b0;
      if (div_start) begin
        starts++; start_cyc = cyc; ss = div_sign; sd = div_dividend; sv = div_divider;
      end
      if (resp_valid != '0) begin rv = resp_valid; break; end
    end
    check({tag, " resp_valid"}, 32'(rv), 32'(oh));
    check({tag, " quotient"}, 32'(resp_quotient), 32'(eq));
    check({tag, " remainder"}, 32'(resp_remainder), 32'(er));
    check({tag, " err"}, 32'(resp_err), 32'(ee));
    check({tag, " busy held"}, 32'(busy_ok), 1);
    check({tag, " no grant while busy"}, 32'(quiet), 1);
    if (dvs[c] == '0) begin
      check({tag, " div0 starts"}, 32'(starts), 0);
      check({tag, " div0 latency"}, 32'(cyc), 1);
    end else begin
      check({tag, " starts"}, 32'(starts), 1);
      check({tag, " start latency"}, 32'(start_cyc), 1);
      check({tag, " div_sign"}, 32'(ss), 32'(sg[c]));
      check({tag, " div_dividend"}, 32'(sd), 32'(dvd[c]));
      check({tag, " div_divider"}, 32'(sv), 32'(dvs[c]));
      if (tmo) check({tag, " timeout latency"}, 32'(cyc), 32'(3 + TO));
      else     check({tag, " latency range"}, 32'(cyc >= 4 && cyc < 3 + TO), 1);
    end
  endtask

  typedef struct {
    int         client;
    bit         sign;
    logic [W-1:0] a, b, q, r;
    bit         err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c;
    logic [W-1:0] eq, er;
    bit ee, ok, saw_low, early;
    logic [N-1:0] pending, g;

    vecs[0] = '{client: 0, sign: 0, a: 13'd1404,  b: 13'd5,      q: 13'd280,    r: 13'd4,  err: 0};
    vecs[1] = '{client: 2, sign: 0, a: 13'd77,    b: 13'd0,      q: 13'h1FFF,   r: 13'd77, err: 1};
    vecs[2] = '{client: 1, sign: 1, a: 13'h1FEC,  b: 13'd3,      q: 13'h1FFA,   r: 13'h1FFE, err: 0};
    vecs[3] = '{client: 3, sign: 0, a: 13'h1FFF,  b: 13'd1,      q: 13'h1FFF,   r: 13'd0,  err: 0};
    vecs[4] = '{client: 1, sign: 0, a: 13'd5,     b: 13'd9,      q: 13'd0,      r: 13'd5,  err: 0};
    vecs[5] = '{client: 0, sign: 1, a: 13'd100,   b: 13'h1FF9,   q: 13'h1FF2,   r: 13'd2,  err: 0};
    vecs[6] = '{client: 3, sign: 1, a: 13'd0,     b: 13'd0,      q: 13'h1FFF,   r: 13'd0,  err: 1};

    checks = 0; errors = 0; last_owner = N - 1;
    reset = 1'b1; req = '0;
    for (int i = 0; i < N; i++) begin
      dvd[i] = W'(100 + 10 * i); dvs[i] = W'(i + 2); sg[i] = 1'b0;
    end
    drive_ops();
    req = '1;
    repeat (3) @(negedge clk);
    #1;
    check("reset grant", 32'(grant), 0);
    check("reset resp_valid", 32'(resp_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset div_start", 32'(div_start), 0);
    check("reset results", {resp_quotient, resp_remainder, 6'(resp_err)}, 0);
    check("reset div operands", {div_dividend, div_divider, 6'(div_sign)}, 0);
    reset = 1'b0;

    // Round robin with all requests held from reset.
    for (int k = 0; k < 5; k++) begin
      c = k % N;
      ref_div(sg[c], dvd[c], dvs[c], eq, er, ee);
      run_one(c, eq, er, ee, 1'b0, (k == 4) ? '1 : '0, $sformatf("rr%0d", k));
    end

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      c = vecs[i].client;
      dvd[c] = vecs[i].a; dvs[c] = vecs[i].b; sg[c] = vecs[i].sign;
      drive_ops();
      req = N'(1) << c;
      run_one(c, vecs[i].q, vecs[i].r, vecs[i].err, 1'b0, N'(1) << c, $sformatf("vec%0d", i));
    end

    // Divider never answers: forced error response, then normal operation.
    @(negedge clk);
    hang = 1'b1;
    dvd[1] = 13'd50; dvs[1] = 13'd7; sg[1] = 1'b0;
    drive_ops();
    req = 4'b0010;
    run_one(1, '0, '0, 1'b1, 1'b1, 4'b0010, "timeout");
    hang = 1'b0;
    @(negedge clk);
    dvd[2] = 13'd60; dvs[2] = 13'd7; sg[2] = 1'b0;
    drive_ops();
    req = 4'b0100;
    run_one(2, 13'd8, 13'd4, 1'b0, 1'b0, 4'b0100, "after timeout");

    // Reset during WAIT.
    @(negedge clk);
    dvd[2] = 13'd900; dvs[2] = 13'd7; sg[2] = 1'b0;
    drive_ops();
    req = 4'b0100;
    wait_grant(g, ok);
    check("rst grant seen", 32'(ok), 1);
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    check("rst busy in wait", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst div_start", 32'(div_start), 0);
    check("rst resp_valid", 32'(resp_valid), 0);
    check("rst results", {resp_quotient, resp_remainder, 6'(resp_err)}, 0);
    check("rst div operands", {div_dividend, div_divider, 6'(div_sign)}, 0);
    @(negedge clk);
    reset = 1'b0;
    last_owner = N - 1;
    dvd[3] = 13'd600; dvs[3] = 13'd25; sg[3] = 1'b0;
    drive_ops();
    req = 4'b1000;
    saw_low = 1'b0; early = 1'b0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (grant != '0) begin ok = 1'b1; break; end
      if (div_ready) early = 1'b1;
      else saw_low = 1'b1;
      @(negedge clk);
    end
    check("post-rst ready was low", 32'(saw_low), 1);
    check("post-rst no grant with ready high", 32'(early), 0);
    check("post-rst grant seen", 32'(ok), 1);
    check("post-rst ready at grant", 32'(div_ready), 1);
    run_one(3, 13'd24, 13'd0, 1'b0, 1'b0, 4'b1000, "post-rst");

    // Random single-client operations.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      c = $urandom_range(0, N - 1);
      dvd[c] = W'($urandom);
      dvs[c] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      sg[c]  = 1'($urandom_range(0, 1));
      drive_ops();
      req = N'(1) << c;
      ref_div(sg[c], dvd[c], dvs[c], eq, er, ee);
      run_one(c, eq, er, ee, 1'b0, N'(1) << c, $sformatf("rnd%0d", i));
    end

    // Random concurrent request sets, order from the round-robin rule.
    for (int rd = 0; rd < 6; rd++) begin
      @(negedge clk);
      pending = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        dvd[i] = W'($urandom);
        dvs[i] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 300));
        sg[i]  = 1'($urandom_range(0, 1));
      end
      drive_ops();
      req = pending;
      while (pending != '0) begin
        c = next_owner(last_owner, pending);
        ref_div(sg[c], dvd[c], dvs[c], eq, er, ee);
        run_one(c, eq, er, ee, 1'b0, N'(1) << c, $sformatf("mix%0d_c%0d", rd, c));
        pending[c] = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
